// File: rtl/branch_resolver.sv
// ID-stage conditional branch resolver: stalls on unresolved operands, issues a
// one-cycle PC redirect / IF/ID flush for taken branches, keeps wrapping perf counters.
module branch_resolver #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  input  logic             br_type,
  input  logic             cmp_eq,
  input  logic             opnd_ready,
  input  logic [PC_W-1:0]  br_target,
  output logic             stall,
  output logic             flush_ifid,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] resolved_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT     = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  state_t state, state_nx;
  logic   taken;
  logic   resolve;
  logic   stall_raw;

  assign taken = br_type ? ~cmp_eq : cmp_eq;

  always_comb begin
    state_nx  = state;
    resolve   = 1'b0;
    stall_raw = 1'b0;
    case (state)
      S_IDLE, S_WAIT: begin
        if (!br_valid) begin
          // an external flush while waiting abandons the branch silently
          state_nx = S_IDLE;
        end else if (opnd_ready) begin
          resolve  = 1'b1;
          state_nx = taken ? S_REDIRECT : S_IDLE;
        end else begin
          stall_raw = 1'b1;
          state_nx  = S_WAIT;
        end
      end
      // ID holds a wrong-path instruction here; it is squashed, never resolved
      S_REDIRECT: state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // gated by rst_n so stall drops the instant reset is asserted
  assign stall          = stall_raw & rst_n;
  assign flush_ifid     = (state == S_REDIRECT);
  assign redirect_valid = (state == S_REDIRECT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      redirect_pc  <= '0;
      taken_cnt    <= '0;
      resolved_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      state <= state_nx;
      if (resolve) begin
        resolved_cnt <= resolved_cnt + CNT_W'(1);
        if (taken) begin
          taken_cnt   <= taken_cnt + CNT_W'(1);
          redirect_pc <= br_target;
        end
      end
      if (stall_raw)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench: behavioural branch model compared every cycle, literal pins, random traffic.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_valid, br_type, cmp_eq, opnd_ready;
  logic [15:0] br_target;
  logic        stall, flush_ifid, redirect_valid;
  logic [15:0] redirect_pc;
  logic [7:0]  taken_cnt, resolved_cnt, stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  branch_resolver #(.PC_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_type(br_type),
    .cmp_eq(cmp_eq), .opnd_ready(opnd_ready), .br_target(br_target),
    .stall(stall), .flush_ifid(flush_ifid), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .taken_cnt(taken_cnt),
    .resolved_cnt(resolved_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: "is this cycle the redirect bubble", last taken target, counts.
  logic        m_bubble;
  logic [15:0] m_pc;
  logic [7:0]  m_tk, m_rs, m_sc;
  logic        m_taken_now;
  assign m_taken_now = br_type ? !cmp_eq : cmp_eq;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_bubble <= 1'b0;
      m_pc     <= 16'h0;
      m_tk     <= 8'h0;
      m_rs     <= 8'h0;
      m_sc     <= 8'h0;
    end else begin
      if (br_valid && !opnd_ready && !m_bubble) m_sc <= m_sc + 8'd1;
      if (br_valid && opnd_ready && !m_bubble) begin
        m_rs     <= m_rs + 8'd1;
        m_bubble <= m_taken_now;
        if (m_taken_now) begin
          m_tk <= m_tk + 8'd1;
          m_pc <= br_target;
        end
      end else begin
        m_bubble <= 1'b0;
      end
    end
  end

  // Literal pins: 0 stall, 1 flush_ifid, 2 redirect_valid, 3 redirect_pc, 4 taken, 5 resolved, 6 stall_cnt
  logic [6:0]  pm;
  logic [31:0] pv [7];

  function automatic string pin_name(input int k);
    case (k)
      0: return "pin_stall";
      1: return "pin_flush_ifid";
      2: return "pin_redirect_valid";
      3: return "pin_redirect_pc";
      4: return "pin_taken_cnt";
      5: return "pin_resolved_cnt";
      default: return "pin_stall_cnt";
    endcase
  endfunction

  function automatic logic [31:0] pin_act(input int k);
    case (k)
      0: return 32'(stall);
      1: return 32'(flush_ifid);
      2: return 32'(redirect_valid);
      3: return 32'(redirect_pc);
      4: return 32'(taken_cnt);
      5: return 32'(resolved_cnt);
      default: return 32'(stall_cnt);
    endcase
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cmp("stall", 32'(stall), 32'(rst_n && br_valid && !opnd_ready && !m_bubble));
    cmp("flush_ifid", 32'(flush_ifid), 32'(m_bubble));
    cmp("redirect_valid", 32'(redirect_valid), 32'(m_bubble));
    cmp("redirect_pc", 32'(redirect_pc), 32'(m_pc));
    cmp("taken_cnt", 32'(taken_cnt), 32'(m_tk));
    cmp("resolved_cnt", 32'(resolved_cnt), 32'(m_rs));
    cmp("stall_cnt", 32'(stall_cnt), 32'(m_sc));
    for (int k = 0; k < 7; k++)
      if (pm[k]) cmp(pin_name(k), pin_act(k), pv[k]);
  end

  task automatic pin(input int k, input logic [31:0] v);
    pm[k] = 1'b1;
    pv[k] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pm = '0;
  endtask

  task automatic drive(input logic v, input logic t, input logic eq, input logic rdy,
                       input logic [15:0] tgt);
    br_valid   = v;
    br_type    = t;
    cmp_eq     = eq;
    opnd_ready = rdy;
    br_target  = tgt;
  endtask

  initial begin
    pm = '0;
    for (int k = 0; k < 7; k++) pv[k] = 32'h0;
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0040);

    // reset holds everything quiet even with a ready taken branch presented
    tick(); tick();
    for (int k = 0; k < 7; k++) pin(k, 32'h0);
    tick();
    rst_n = 1'b1;
    pin(2, 32'h0); pin(0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    pin(2, 32'h1); pin(1, 32'h1); pin(3, 32'h0040); pin(4, 32'h1); pin(5, 32'h1);
    tick();
    pin(2, 32'h0); pin(1, 32'h0);
    tick();

    // BEQ not taken then BNE taken (operands differ)
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0080);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0100);
    pin(2, 32'h0); pin(5, 32'h2); pin(4, 32'h1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    pin(2, 32'h1); pin(3, 32'h0100); pin(5, 32'h3); pin(4, 32'h2);
    tick();

    // hazard: three stall cycles, then resolve taken
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0200);
    for (int i = 0; i < 3; i++) begin
      pin(0, 32'h1); pin(6, 32'(i));
      tick();
    end
    opnd_ready = 1'b1;
    pin(0, 32'h0); pin(6, 32'h3); pin(2, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    pin(2, 32'h1); pin(3, 32'h0200);
    tick();

    // squash: taken BNE sitting in ID during the redirect bubble
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0300);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0400);
    pin(2, 32'h1); pin(3, 32'h0300); pin(4, 32'h4); pin(5, 32'h5);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    pin(2, 32'h0); pin(3, 32'h0300); pin(4, 32'h4); pin(5, 32'h5);
    tick();

    // abort: branch withdrawn while waiting
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0500);
    tick(); tick();
    br_valid = 1'b0;
    pin(0, 32'h0); pin(6, 32'h5);
    tick();
    pin(2, 32'h0); pin(4, 32'h4); pin(5, 32'h5); pin(6, 32'h5);
    tick();

    // asynchronous reset in the middle of a WAIT cycle
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0600);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    pin(0, 32'h0); pin(2, 32'h0); pin(3, 32'h0); pin(4, 32'h0); pin(5, 32'h0); pin(6, 32'h0);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    tick();

    // wrap: 256 taken branches bring both counters back to zero
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'(i % 2), 1'(1 - (i % 2)), 1'b1, 16'($urandom));
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
      tick();
    end
    pin(4, 32'h0); pin(5, 32'h0);
    tick();

    // random traffic with occasional mid-cycle resets
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 9) < 6), 16'($urandom));
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
